// File: rtl/calc_pkg.sv
// Shared definitions for the calculator digit-entry path: BCD digit width, limit and single-digit step helpers.
package calc_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_CLR,
    OP_INC,
    OP_DEC
  } op_e;

  // Returns {carry, digit}; carry doubles as the "digit is nine" flag.
  function automatic logic [BCD_W:0] bcd_inc(input logic [BCD_W-1:0] d);
    logic [BCD_W:0] r;
    if (d >= BCD_MAX) r = {1'b1, {BCD_W{1'b0}}};
    else              r = {1'b0, d + BCD_W'(1)};
    return r;
  endfunction

  // Returns {borrow, digit}; borrow doubles as the "digit is zero" flag.
  function automatic logic [BCD_W:0] bcd_dec(input logic [BCD_W-1:0] d);
    logic [BCD_W:0] r;
    if (d == '0) r = {1'b1, BCD_MAX};
    else         r = {1'b0, d - BCD_W'(1)};
    return r;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Raw push-button conditioning: synchroniser chain, debouncer and rising-edge pulse.
module btn_conditioner #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   w_s;
  logic                   w_level;
  logic                   r_level_q;
  logic                   r_armed;

  assign w_s = r_sync[SYNC_STAGES-1];

  // r_fill marks when the chain holds only post-reset samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_fill <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], btn_raw};
      r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  if (DEBOUNCE_CYC == 0) begin : g_bypass
    assign w_level = w_s;
  end else begin : g_debounce
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt   <= '0;
        r_level <= 1'b0;
      end else if (w_s == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
        r_level <= w_s;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    assign w_level = r_level;
  end

  // Edges are only honoured once the button has been seen released after reset,
  // so a press held through reset never counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_level_q <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_level_q <= w_level;
      r_armed   <= r_armed | (r_fill[SYNC_STAGES-1] & ~w_s & ~w_level);
    end
  end

  assign level = w_level;
  assign rise  = w_level & ~r_level_q & r_armed;

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter stepped by debounced inc/dec push-buttons, with clear, step and wrap pulses.
module bcd_updown_counter
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inc_btn,
  input  logic                      dec_btn,
  input  logic                      clr,
  output logic [BCD_W*DIGITS-1:0]   count,
  output logic                      step,
  output logic                      wrap
);

  localparam int unsigned CNT_W = BCD_W * DIGITS;

  logic             w_inc_p;
  logic             w_dec_p;
  logic             w_inc_lvl;
  logic             w_dec_lvl;
  logic             w_unused_lvl;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_inc_val;
  logic [CNT_W-1:0] w_dec_val;
  logic [CNT_W-1:0] w_count_nxt;
  logic [DIGITS-1:0] w_is9;
  logic [DIGITS-1:0] w_is0;
  logic             r_step;
  logic             r_wrap;
  logic             w_step_nxt;
  logic             w_wrap_nxt;
  op_e              w_op;

  btn_conditioner #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_inc_btn (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(inc_btn),
    .level  (w_inc_lvl),
    .rise   (w_inc_p)
  );

  btn_conditioner #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_dec_btn (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(dec_btn),
    .level  (w_dec_lvl),
    .rise   (w_dec_p)
  );

  // Debounced levels are available for observation but the count only uses edges.
  assign w_unused_lvl = w_inc_lvl ^ w_dec_lvl;

  // A digit moves when every lower digit is at its limit (all nines up, all zeros down).
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [BCD_W-1:0] w_cur;
    logic [BCD_W:0]   w_inc_d;
    logic [BCD_W:0]   w_dec_d;
    logic             w_cin;
    logic             w_bin;

    assign w_cur       = r_count[gi*BCD_W +: BCD_W];
    assign w_inc_d     = bcd_inc(w_cur);
    assign w_dec_d     = bcd_dec(w_cur);
    assign w_is9[gi]   = w_inc_d[BCD_W];
    assign w_is0[gi]   = w_dec_d[BCD_W];

    if (gi == 0) begin : g_lsd
      assign w_cin = 1'b1;
      assign w_bin = 1'b1;
    end else begin : g_upper
      assign w_cin = &w_is9[gi-1:0];
      assign w_bin = &w_is0[gi-1:0];
    end

    assign w_inc_val[gi*BCD_W +: BCD_W] = w_cin ? w_inc_d[BCD_W-1:0] : w_cur;
    assign w_dec_val[gi*BCD_W +: BCD_W] = w_bin ? w_dec_d[BCD_W-1:0] : w_cur;
  end

  always_comb begin
    w_op        = OP_HOLD;
    w_count_nxt = r_count;
    w_step_nxt  = 1'b0;
    w_wrap_nxt  = 1'b0;

    if (clr)                     w_op = OP_CLR;
    else if (w_inc_p && w_dec_p) w_op = OP_HOLD;
    else if (w_inc_p)            w_op = OP_INC;
    else if (w_dec_p)            w_op = OP_DEC;

    case (w_op)
      OP_CLR: w_count_nxt = '0;
      OP_INC: begin
        w_count_nxt = w_inc_val;
        w_step_nxt  = 1'b1;
        w_wrap_nxt  = &w_is9;
      end
      OP_DEC: begin
        w_count_nxt = w_dec_val;
        w_step_nxt  = 1'b1;
        w_wrap_nxt  = &w_is0;
      end
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_step  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_step  <= w_step_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign count = r_count;
  assign step  = r_step;
  assign wrap  = r_wrap;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench: directed scenarios plus randomized button activity against a decimal-value reference model.
module tb_bcd_updown_counter;

  localparam int S = 2;
  localparam int D = 4;

  logic       clk;
  logic       reset;
  logic       inc_btn, dec_btn, clr;
  logic [7:0] count;
  logic       step, wrap;
  logic       inc0, dec0, clr0;
  logic [7:0] count0;
  logic       step0, wrap0;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_updown_counter #(.DIGITS(2), .DEBOUNCE_CYC(D), .SYNC_STAGES(S)) u_dut (
    .clk(clk), .reset(reset), .inc_btn(inc_btn), .dec_btn(dec_btn), .clr(clr),
    .count(count), .step(step), .wrap(wrap)
  );

  bcd_updown_counter #(.DIGITS(2), .DEBOUNCE_CYC(0), .SYNC_STAGES(S)) u_dut0 (
    .clk(clk), .reset(reset), .inc_btn(inc0), .dec_btn(dec0), .clr(clr0),
    .count(count0), .step(step0), .wrap(wrap0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Reference model: count kept as a plain integer 0..99; buttons seen through an
  // (S-1)-edge delay, accepted after D consecutive differing samples.
  int       m_val = 0;
  bit       m_step = 0, m_wrap = 0, m_valid = 0;
  bit [S-1:0] m_sh[2];
  bit       m_L[2];
  int       m_run[2];
  bit       m_armed[2];
  bit       m_p[2];
  int       m_age = 0;

  task automatic model_edge();
    bit raw[2];
    bit s_old, l_old;
    raw[0] = inc_btn;
    raw[1] = dec_btn;
    if (reset) begin
      m_val = 0; m_step = 0; m_wrap = 0; m_age = 0; m_valid = 1;
      for (int b = 0; b < 2; b++) begin
        m_sh[b] = '0; m_L[b] = 0; m_run[b] = 0; m_armed[b] = 0; m_p[b] = 0;
      end
      return;
    end
    m_step = 0;
    m_wrap = 0;
    if (clr) m_val = 0;
    else if (m_p[0] && m_p[1]) begin end
    else if (m_p[0]) begin m_step = 1; m_wrap = (m_val == 99); m_val = (m_val + 1) % 100; end
    else if (m_p[1]) begin m_step = 1; m_wrap = (m_val == 0);  m_val = (m_val + 99) % 100; end
    for (int b = 0; b < 2; b++) begin
      s_old = m_sh[b][S-1];
      l_old = m_L[b];
      if (m_age >= S && !s_old && !l_old) m_armed[b] = 1;
      if (s_old != l_old) begin
        m_run[b]++;
        if (m_run[b] >= D) begin m_L[b] = s_old; m_run[b] = 0; end
      end else begin
        m_run[b] = 0;
      end
      m_sh[b] = {m_sh[b][S-2:0], raw[b]};
      m_p[b]  = m_L[b] && !l_old && m_armed[b];
    end
    if (m_age < 1000) m_age++;
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("cmp_count", 32'(count), 32'(to_bcd(m_val)));
      chk("cmp_step",  32'(step),  32'(m_step));
      chk("cmp_wrap",  32'(wrap),  32'(m_wrap));
    end
  end

  int         n_seen;
  logic [7:0] c_seen;
  logic       w_seen;

  task automatic watch(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (step === 1'b1) begin
        n_seen++;
        c_seen = count;
        w_seen = wrap;
      end
    end
  endtask

  task automatic press(input logic pi, input logic pd);
    n_seen = 0;
    c_seen = 8'hEE;
    w_seen = 1'b0;
    @(negedge clk); inc_btn = pi; dec_btn = pd;
    watch(14);
    @(negedge clk); inc_btn = 1'b0; dec_btn = 1'b0;
    watch(14);
  endtask

  task automatic press_chk(input string nm, input logic pi, input logic pd,
                           input logic [7:0] exp_c, input logic exp_w, input int exp_steps);
    press(pi, pd);
    chk({nm, "_steps"}, 32'(n_seen), 32'(exp_steps));
    if (exp_steps > 0) begin
      chk({nm, "_count_at_step"}, 32'(c_seen), 32'(exp_c));
      chk({nm, "_wrap_at_step"},  32'(w_seen), 32'(exp_w));
    end
    chk({nm, "_count"}, 32'(count), 32'(exp_c));
  endtask

  // Edges from the first raw-sampling edge up to and including the step edge.
  task automatic latency(input bit on0, output int lat);
    lat = 0;
    @(negedge clk);
    if (on0) inc0 = 1'b1; else inc_btn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if ((on0 ? step0 : step) === 1'b1) break;
    end
    watch(10);
    @(negedge clk); inc0 = 1'b0; inc_btn = 1'b0;
    watch(14);
  endtask

  initial begin
    int lat;
    reset = 1'b1; inc_btn = 1'b0; dec_btn = 1'b0; clr = 1'b0;
    inc0 = 1'b0; dec0 = 1'b0; clr0 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_count",  32'(count),  32'h0);
    chk("rst_step",   32'(step),   32'h0);
    chk("rst_wrap",   32'(wrap),   32'h0);
    chk("rst_count0", 32'(count0), 32'h0);

    press_chk("inc1", 1'b1, 1'b0, 8'h01, 1'b0, 1);
    press_chk("inc2", 1'b1, 1'b0, 8'h02, 1'b0, 1);
    press_chk("inc3", 1'b1, 1'b0, 8'h03, 1'b0, 1);

    latency(1'b0, lat); chk("latency_d4_a", 32'(lat), 32'd7);
    latency(1'b0, lat); chk("latency_d4_b", 32'(lat), 32'd7);
    chk("after_latency", 32'(count), 32'h05);

    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("clr", 32'(count), 32'h0);

    press_chk("dec_00",    1'b0, 1'b1, 8'h99, 1'b1, 1);
    press_chk("inc_99",    1'b1, 1'b0, 8'h00, 1'b1, 1);
    press_chk("dec_wrap",  1'b0, 1'b1, 8'h99, 1'b1, 1);
    press_chk("inc_wrap2", 1'b1, 1'b0, 8'h00, 1'b1, 1);
    for (int i = 0; i < 9; i++) press(1'b1, 1'b0);
    chk("nine_incs", 32'(count), 32'h09);
    press_chk("carry",  1'b1, 1'b0, 8'h10, 1'b0, 1);
    press_chk("borrow", 1'b0, 1'b1, 8'h09, 1'b0, 1);

    // Bouncing press: toggles every 2 cycles, then settles high.
    n_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); inc_btn = ~inc_btn;
      watch(1);
      @(negedge clk);
      watch(1);
    end
    @(negedge clk); inc_btn = 1'b1;
    watch(14);
    @(negedge clk); inc_btn = 1'b0;
    watch(14);
    chk("bounce_steps", 32'(n_seen), 32'd1);
    chk("bounce_count", 32'(count),  32'h10);

    n_seen = 0;
    @(negedge clk); inc_btn = 1'b1;
    watch(3);
    @(negedge clk); inc_btn = 1'b0;
    watch(14);
    chk("glitch_steps", 32'(n_seen), 32'd0);
    chk("glitch_count", 32'(count),  32'h10);

    press_chk("both", 1'b1, 1'b1, 8'h10, 1'b0, 0);

    // clr lands on the same edge the inc pulse would update the count.
    n_seen = 0;
    @(negedge clk); inc_btn = 1'b1;
    watch(6);
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1;
    chk("clr_inc_count", 32'(count), 32'h0);
    chk("clr_inc_step",  32'(step),  32'h0);
    @(negedge clk); clr = 1'b0;
    watch(10);
    @(negedge clk); inc_btn = 1'b0;
    watch(14);
    chk("clr_inc_steps", 32'(n_seen), 32'd0);

    latency(1'b1, lat); chk("latency_d0_a", 32'(lat), 32'd3);
    latency(1'b1, lat); chk("latency_d0_b", 32'(lat), 32'd3);
    chk("count0", 32'(count0), 32'h02);

    // Press held through a reset pulse.
    n_seen = 0;
    @(negedge clk); inc_btn = 1'b1;
    watch(14);
    chk("hold_step", 32'(n_seen), 32'd1);
    @(negedge clk); reset = 1'b1;
    watch(2);
    @(negedge clk); reset = 1'b0;
    n_seen = 0;
    watch(30);
    chk("held_reset_steps", 32'(n_seen), 32'd0);
    chk("held_reset_count", 32'(count),  32'h0);
    @(negedge clk); inc_btn = 1'b0;
    watch(14);
    chk("release_steps", 32'(n_seen), 32'd0);
    press_chk("repress", 1'b1, 1'b0, 8'h01, 1'b0, 1);

    for (int blk = 0; blk < 40; blk++) begin
      int pr;
      pr = int'($urandom_range(2, 24));
      repeat (60) begin
        @(negedge clk);
        if ($urandom_range(0, pr - 1) == 0) inc_btn = ~inc_btn;
        if ($urandom_range(0, pr - 1) == 0) dec_btn = ~dec_btn;
        clr   = ($urandom_range(0, 79) == 0);
        reset = ($urandom_range(0, 599) == 0);
      end
    end
    @(negedge clk);
    inc_btn = 1'b0; dec_btn = 1'b0; clr = 1'b0; reset = 1'b0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
